// File: rtl/calc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | calc_pkg                                                             |
// | Shared calculator opcodes and division sequencer state encoding.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package calc_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_NOT = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_step                                                             |
// | One combinational restoring-division step (one quotient bit).        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] r,
   input  logic             q_msb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] r_next,
   output logic             q_bit
);

   logic [WIDTH:0]   w_shift;
   logic [WIDTH-1:0] w_diff;

   // The shifted remainder may carry into bit WIDTH, so compare at WIDTH+1 bits;
   // when it does, the true difference is below divisor and fits in WIDTH bits.
   assign w_shift = {r, q_msb};
   assign w_diff  = w_shift[WIDTH-1:0] - divisor;
   assign q_bit   = (w_shift >= {1'b0, divisor});
   assign r_next  = q_bit ? w_diff : w_shift[WIDTH-1:0];

endmodule : div_step
`default_nettype wire

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_seq_ctrl                                                         |
// | Multi-cycle restoring divider sequencer with divide-by-zero flag.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module div_seq_ctrl
   import calc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       sel,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             erro
);

   localparam logic [CNT_W-1:0] c_last_step = CNT_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_erro;

   logic             w_accept;
   logic             w_div_zero;
   logic             w_last;
   logic [WIDTH-1:0] w_r_next;
   logic             w_q_bit;

   assign w_accept   = (r_state == IDLE) && start && (sel == OP_DIV);
   assign w_div_zero = (divisor == '0);
   assign w_last     = (r_cnt == c_last_step);

   div_step #(
      .WIDTH   (WIDTH)
   ) u_div_step (
      .r       (r_rem),
      .q_msb   (r_q[WIDTH-1]),
      .divisor (r_div),
      .r_next  (w_r_next),
      .q_bit   (w_q_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_next = w_div_zero ? DONE : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (w_last) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            busy         = 1'b1;
            done         = 1'b1;
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // r_q doubles as dividend shifter (MSB feeds the step) and quotient collector.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_rem       <= '0;
         r_q         <= '0;
         r_div       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_erro      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_div_zero) begin
                     r_erro      <= 1'b1;
                     r_quotient  <= '0;
                     r_remainder <= '0;
                  end else begin
                     r_erro <= 1'b0;
                     r_q    <= dividend;
                     r_div  <= divisor;
                     r_rem  <= '0;
                     r_cnt  <= '0;
                  end
               end
            end
            RUN: begin
               r_rem <= w_r_next;
               r_q   <= {r_q[WIDTH-2:0], w_q_bit};
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_quotient  <= {r_q[WIDTH-2:0], w_q_bit};
                  r_remainder <= w_r_next;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign quotient  = r_quotient;
   assign remainder = r_remainder;
   assign erro      = r_erro;

endmodule : div_seq_ctrl
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_div_seq_ctrl                                                      |
// | Scoreboard bench for the division sequencer.                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_div_seq_ctrl;
   import calc_pkg::*;

   typedef struct packed {
      logic [7:0] q;
      logic [7:0] r;
      logic       e;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [2:0] sel = 3'b000;
   logic [7:0] dividend = 8'd0;
   logic [7:0] divisor = 8'd0;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       erro;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   div_seq_ctrl #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sel       (sel),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .erro      (erro)
   );

   // Drive one request across one accept edge; push the model's answer when it should be taken.
   task automatic drive_req(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      @(posedge clk);
      #1;
      sel = s; dividend = a; divisor = b; start = 1'b1;
      if (s == OP_DIV) begin
         if (b == 8'd0) e = '{q: 8'd0, r: 8'd0, e: 1'b1};
         else           e = '{q: a / b, r: a % b, e: 1'b0};
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Watch max_cyc cycles after the accept edge; optionally re-pulse start at cycle inj_cyc.
   task automatic observe(input int max_cyc, input int inj_cyc,
                          input logic [7:0] inj_a, input logic [7:0] inj_b,
                          output int done_cyc, output int busy_cnt, output int done_cnt,
                          output logic [7:0] dq, output logic [7:0] dr, output logic de,
                          output logic [7:0] fq, output logic [7:0] fr);
      done_cyc = 0; busy_cnt = 0; done_cnt = 0;
      dq = 8'hxx; dr = 8'hxx; de = 1'bx;
      for (int k = 1; k <= max_cyc; k++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_cyc == 0) begin
               done_cyc = k; dq = quotient; dr = remainder; de = erro;
            end
         end
         if (k == inj_cyc) begin
            start = 1'b1; sel = OP_DIV; dividend = inj_a; divisor = inj_b;
         end else if (k == inj_cyc + 1) begin
            start = 1'b0;
         end
      end
      fq = quotient;
      fr = remainder;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (quotient !== 8'd0)  begin errors++; $display("FAIL reset_q got %0d want 0", quotient); end
      checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL reset_r got %0d want 0", remainder); end
      checks++; if (erro !== 1'b0)      begin errors++; $display("FAIL reset_erro got %b want 0", erro); end
      rst = 1'b0;
   endtask

   // Full request with scoreboard compare; want_cyc is the expected done latency.
   task automatic run_one(input string name, input logic [7:0] a, input logic [7:0] b, input int want_cyc);
      int dc, bc, nc;
      logic [7:0] dq, dr, fq, fr;
      logic de;
      exp_t e;
      drive_req(OP_DIV, a, b);
      observe(want_cyc + 3, 0, 8'd0, 8'd0, dc, bc, nc, dq, dr, de, fq, fr);
      checks++; if (dc !== want_cyc) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, dc, want_cyc); end
      checks++; if (bc !== want_cyc) begin errors++; $display("FAIL %s_busy_cycles got %0d want %0d", name, bc, want_cyc); end
      checks++; if (nc !== 1)        begin errors++; $display("FAIL %s_done_pulses got %0d want 1", name, nc); end
      if (exp_q.size() == 0) begin
         checks++; errors++; $display("FAIL %s_scoreboard got empty want entry", name);
      end else begin
         e = exp_q.pop_front();
         checks++; if (dq !== e.q) begin errors++; $display("FAIL %s_q got %0d want %0d", name, dq, e.q); end
         checks++; if (dr !== e.r) begin errors++; $display("FAIL %s_r got %0d want %0d", name, dr, e.r); end
         checks++; if (de !== e.e) begin errors++; $display("FAIL %s_erro got %b want %b", name, de, e.e); end
         checks++; if (fq !== e.q) begin errors++; $display("FAIL %s_hold_q got %0d want %0d", name, fq, e.q); end
         checks++; if (fr !== e.r) begin errors++; $display("FAIL %s_hold_r got %0d want %0d", name, fr, e.r); end
      end
   endtask

   task automatic test_basic();
      run_one("div100_7", 8'd100, 8'd7, 9);
      run_one("div0_13", 8'd0, 8'd13, 9);
   endtask

   task automatic test_div_zero();
      run_one("div55_0", 8'd55, 8'd0, 1);
      drive_req(OP_DIV, 8'd255, 8'd1);
      @(negedge clk);
      checks++; if (erro !== 1'b0) begin errors++; $display("FAIL erro_clear_at_accept got %b want 0", erro); end
      begin
         int dc, bc, nc;
         logic [7:0] dq, dr, fq, fr;
         logic de;
         exp_t e;
         observe(10, 0, 8'd0, 8'd0, dc, bc, nc, dq, dr, de, fq, fr);
         e = exp_q.pop_front();
         checks++; if (dc !== 8) begin errors++; $display("FAIL div255_1_latency got %0d want 9", dc + 1); end
         checks++; if (dq !== e.q) begin errors++; $display("FAIL div255_1_q got %0d want %0d", dq, e.q); end
         checks++; if (dr !== e.r) begin errors++; $display("FAIL div255_1_r got %0d want %0d", dr, e.r); end
      end
   endtask

   task automatic test_wrong_sel();
      int dc, bc, nc;
      logic [7:0] dq, dr, fq, fr;
      logic de;
      drive_req(OP_MUL, 8'd77, 8'd3);
      observe(12, 0, 8'd0, 8'd0, dc, bc, nc, dq, dr, de, fq, fr);
      checks++; if (bc !== 0) begin errors++; $display("FAIL wrong_sel_busy got %0d cycles want 0", bc); end
      checks++; if (nc !== 0) begin errors++; $display("FAIL wrong_sel_done got %0d pulses want 0", nc); end
      checks++; if (fq !== 8'd255 || fr !== 8'd0 || erro !== 1'b0)
         begin errors++; $display("FAIL wrong_sel_hold got q=%0d r=%0d e=%b want q=255 r=0 e=0", fq, fr, erro); end
      run_one("div5_9", 8'd5, 8'd9, 9);
   endtask

   task automatic test_back_to_back();
      int dc, bc, nc;
      logic [7:0] dq, dr, fq, fr;
      logic de;
      exp_t e;
      drive_req(OP_DIV, 8'd200, 8'd3);
      observe(12, 4, 8'd10, 8'd2, dc, bc, nc, dq, dr, de, fq, fr);
      e = exp_q.pop_front();
      checks++; if (dc !== 9) begin errors++; $display("FAIL ignore_run_latency got %0d want 9", dc); end
      checks++; if (nc !== 1) begin errors++; $display("FAIL ignore_run_pulses got %0d want 1", nc); end
      checks++; if (dq !== e.q || dr !== e.r)
         begin errors++; $display("FAIL ignore_run_result got q=%0d r=%0d want q=%0d r=%0d", dq, dr, e.q, e.r); end
      checks++; if (bc !== 9) begin errors++; $display("FAIL ignore_run_busy got %0d want 9", bc); end
   endtask

   task automatic test_reset_mid_run();
      int nc = 0;
      drive_req(OP_DIV, 8'd200, 8'd3);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (done) nc++;
      end
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      checks++; if (busy !== 1'b0 || done !== 1'b0)
         begin errors++; $display("FAIL midrun_reset_ctrl got busy=%b done=%b want 0 0", busy, done); end
      checks++; if (quotient !== 8'd0 || remainder !== 8'd0 || erro !== 1'b0)
         begin errors++; $display("FAIL midrun_reset_out got q=%0d r=%0d e=%b want 0 0 0", quotient, remainder, erro); end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done) nc++;
      end
      checks++; if (nc !== 0) begin errors++; $display("FAIL midrun_reset_done got %0d pulses want 0", nc); end
      run_one("div9_4", 8'd9, 8'd4, 9);
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div_zero();
      test_wrong_sel();
      test_back_to_back();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_div_seq_ctrl
`default_nettype wire
